inst_mem_responder: RTL and testbench

Memory-side responder for the instruction fetch path. It accepts one fetch request at a time (address valid/ready), checks it, reads a 64-bit word from a synchronous single-port SRAM and returns the selected 32-bit instruction with an error flag (response valid/ready).
It sits between the fetch unit and the instruction SRAM and replaces the DPI fetch path in synthesizable builds.
A programmable response latency lets the bench model a slow memory.

---
 rtl/inst_mem_responder_pkg.sv | 18 +
 rtl/inst_mem_responder_addr_check.sv | 37 +++
 rtl/inst_mem_responder.sv | 122 ++++++++++++
 tb/tb_inst_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_responder_pkg.sv
// inst_mem_responder_pkg
// Shared definitions for the instruction-fetch memory responder:
// the FSM state encoding, the reset PC (which is also the base of the
// instruction SRAM window) and the instruction width used by the fetch
// and decode stages.
package inst_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          INST_W   = 32;
  localparam int          CNT_W    = 4;

endpackage

// File: rtl/inst_mem_responder_addr_check.sv
// imem_addr_check
// Combinational legality check and SRAM word index for a fetch address.
// Ports:
//   addr      in   ADDR_WIDTH    fetch byte address
//   err       out  1             misaligned or outside [BASE_ADDR, BASE_ADDR+MEM_BYTES)
//   word_idx  out  ADDR_WIDTH-3  (addr-BASE_ADDR)>>3
//   upper     out  1             selects the high instruction of the 64-bit word
module imem_addr_check
  import inst_mem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(RESET_PC),
  parameter int unsigned           MEM_BYTES  = 65536
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  err,
  output logic [ADDR_WIDTH-4:0] word_idx,
  output logic                  upper
);

  logic [ADDR_WIDTH-1:0] offset;
  logic                  below;
  logic                  beyond;

  // The upper bound is tested on the offset, which is only meaningful once
  // addr >= BASE_ADDR; this keeps BASE_ADDR+MEM_BYTES from ever being
  // formed and so nothing can wrap at the top of the address space.
  always_comb begin
    offset   = addr - BASE_ADDR;
    below    = addr < BASE_ADDR;
    beyond   = offset >= ADDR_WIDTH'(MEM_BYTES);
    err      = (addr[1:0] != 2'b00) | below | beyond;
    word_idx = offset[ADDR_WIDTH-1:3];
    upper    = offset[2];
  end

endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder
// Memory-side responder for instruction fetch. Accepts one request at a
// time, reads a 64-bit word from a synchronous SRAM and returns the
// selected 32-bit instruction after LATENCY cycles (legal range 1..15).
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready request handshake, req_addr = fetch byte address
//   resp_valid/ready response handshake, resp_inst/resp_err = result
//   mem_ren         one-cycle SRAM read strobe, same cycle as the accept
//   mem_raddr       SRAM word index, mem_rdata valid the cycle after mem_ren
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = INST_W,
  parameter int                    MEM_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(RESET_PC),
  parameter int unsigned           MEM_BYTES  = 65536,
  parameter int                    LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [INST_WIDTH-1:0] resp_inst,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-4:0] mem_raddr,
  input  logic [MEM_WIDTH-1:0]  mem_rdata
);

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  accept;
  logic                  chk_err;
  logic                  chk_upper;
  logic [ADDR_WIDTH-4:0] chk_idx;
  logic                  rd_pending_q;
  logic                  upper_q;
  logic                  err_q;
  logic [INST_WIDTH-1:0] hold_q;
  logic [INST_WIDTH-1:0] sel_data;

  imem_addr_check #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE_ADDR),
    .MEM_BYTES (MEM_BYTES)
  ) u_addr_check (
    .addr    (req_addr),
    .err     (chk_err),
    .word_idx(chk_idx),
    .upper   (chk_upper)
  );

  assign accept   = req_valid & req_ready;
  assign sel_data = upper_q ? mem_rdata[MEM_WIDTH-1 -: INST_WIDTH]
                            : mem_rdata[INST_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The SRAM returns data only for the cycle after mem_ren, so in that cycle
  // the response is taken straight from mem_rdata (needed when LATENCY==1)
  // and from then on from the holding register.
  always_comb begin
    req_ready  = (state_q == IDLE) & ~rst;
    mem_ren    = accept & ~chk_err;
    mem_raddr  = mem_ren ? chk_idx : '0;
    resp_valid = (state_q == RESP);
    resp_err   = resp_valid & err_q;
    resp_inst  = '0;
    if (resp_valid) begin
      resp_inst = rd_pending_q ? sel_data : hold_q;
    end
  end

  // Errored requests clear the holding register at accept and never raise
  // rd_pending, so they report an all-zero instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      upper_q      <= 1'b0;
      err_q        <= 1'b0;
      hold_q       <= '0;
    end else if (accept) begin
      cnt_q        <= CNT_W'(LATENCY - 1);
      rd_pending_q <= ~chk_err;
      upper_q      <= chk_upper;
      err_q        <= chk_err;
      hold_q       <= '0;
    end else begin
      rd_pending_q <= 1'b0;
      if (rd_pending_q) begin
        hold_q <= sel_data;
      end
      if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder
// Directed bench for inst_mem_responder. Three instances (LATENCY 1, 3, 4)
// share clock, reset, address and resp_ready; each has its own SRAM model
// that returns a fixed pattern and drives junk when not being read.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] req_addr = '0;
  logic        resp_ready = 1'b0;

  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_inst  [3];
  logic        resp_err   [3];
  logic        mem_ren    [3];
  logic [60:0] mem_raddr  [3];
  logic [63:0] mem_rdata  [3];

  int ren_cnt [3] = '{0, 0, 0};
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inst_mem_responder #(
      .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready),
      .resp_inst (resp_inst[g]),
      .resp_err  (resp_err[g]),
      .mem_ren   (mem_ren[g]),
      .mem_raddr (mem_raddr[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  function automatic logic [63:0] sram_word(input logic [60:0] idx);
    if (idx == 61'd0) return 64'h00000513_00000297;
    return {32'h1000_0000 + idx[31:0], 32'h2000_0000 + idx[31:0]};
  endfunction

  function automatic logic [31:0] model_inst(input logic [63:0] pc);
    logic [63:0] w;
    w = sram_word(61'((pc - 64'h8000_0000) >> 3));
    return pc[2] ? w[63:32] : w[31:0];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (mem_ren[i]) begin
        ren_cnt[i]   <= ren_cnt[i] + 1;
        mem_rdata[i] <= sram_word(mem_raddr[i]);
      end else begin
        mem_rdata[i] <= 64'hDEADBEEF_DEADBEEF;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One complete fetch on instance g: accept, latency window, optional
  // backpressure (with a competing request held), handshake, back to IDLE.
  task automatic apply_stimulus(input int g, input int lat, input logic [63:0] addr,
                                input logic exp_err, input logic [31:0] exp_inst,
                                input int hold, input logic keep_ready);
    int ren_before;
    ren_before   = ren_cnt[g];
    req_addr     = addr;
    req_valid[g] = 1'b1;
    resp_ready   = keep_ready;
    #2;
    check_output("accept_ready", 64'(req_ready[g]), 64'd1);
    check_output("accept_ren", 64'(mem_ren[g]), 64'(!exp_err));
    check_output("accept_raddr", 64'(mem_raddr[g]),
                 exp_err ? 64'd0 : ((addr - 64'h8000_0000) >> 3));
    tick();
    req_valid[g] = 1'b0;
    for (int c = 1; c < lat; c++) begin
      #2;
      check_output("wait_valid", 64'(resp_valid[g]), 64'd0);
      check_output("wait_ready", 64'(req_ready[g]), 64'd0);
      tick();
    end
    #2;
    check_output("resp_valid", 64'(resp_valid[g]), 64'd1);
    check_output("resp_inst", 64'(resp_inst[g]), 64'(exp_inst));
    check_output("resp_err", 64'(resp_err[g]), 64'(exp_err));
    check_output("resp_ready_low", 64'(req_ready[g]), 64'd0);
    for (int h = 0; h < hold; h++) begin
      req_valid[g] = 1'b1;
      req_addr     = addr + 64'd8;
      tick();
      #2;
      check_output("bp_valid", 64'(resp_valid[g]), 64'd1);
      check_output("bp_inst", 64'(resp_inst[g]), 64'(exp_inst));
      check_output("bp_ready", 64'(req_ready[g]), 64'd0);
      check_output("bp_ren", 64'(mem_ren[g]), 64'd0);
    end
    req_valid[g] = 1'b0;
    req_addr     = addr;
    resp_ready   = 1'b1;
    tick();
    resp_ready = keep_ready;
    #2;
    check_output("done_valid", 64'(resp_valid[g]), 64'd0);
    check_output("done_idle", 64'(req_ready[g]), 64'd1);
    check_output("ren_count", 64'(ren_cnt[g] - ren_before), exp_err ? 64'd0 : 64'd1);
  endtask

  initial begin
    int start_cyc;
    logic [63:0] pc;
    for (int i = 0; i < 3; i++) req_valid[i] = 1'b0;

    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      check_output("rst_ready", 64'(req_ready[i]), 64'd0);
      check_output("rst_valid", 64'(resp_valid[i]), 64'd0);
      check_output("rst_inst", 64'(resp_inst[i]), 64'd0);
      check_output("rst_ren", 64'(mem_ren[i]), 64'd0);
      check_output("rst_raddr", 64'(mem_raddr[i]), 64'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) check_output("post_rst_ready", 64'(req_ready[i]), 64'd1);

    $display("[TB] aligned fetch, LATENCY=1");
    apply_stimulus(0, 1, 64'h8000_0000, 1'b0, 32'h0000_0297, 0, 1'b0);

    $display("[TB] upper half, LATENCY=3, 5 cycles of backpressure");
    apply_stimulus(1, 3, 64'h8000_0004, 1'b0, 32'h0000_0513, 5, 1'b0);

    $display("[TB] error and window-edge addresses");
    apply_stimulus(0, 1, 64'h8000_0002, 1'b1, 32'h0, 0, 1'b0);
    apply_stimulus(0, 1, 64'h8000_0001, 1'b1, 32'h0, 0, 1'b0);
    apply_stimulus(0, 1, 64'h7FFF_FFFC, 1'b1, 32'h0, 0, 1'b0);
    apply_stimulus(0, 1, 64'h8001_0000, 1'b1, 32'h0, 0, 1'b0);
    apply_stimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'h0, 0, 1'b0);
    apply_stimulus(0, 1, 64'h8000_FFFC, 1'b0, 32'h1000_1FFF, 0, 1'b0);
    apply_stimulus(2, 4, 64'h8000_FFF8, 1'b0, 32'h2000_1FFF, 0, 1'b0);

    $display("[TB] reset during WAIT, LATENCY=4");
    req_addr     = 64'h8000_0008;
    req_valid[2] = 1'b1;
    #2;
    check_output("abort_accept_ren", 64'(mem_ren[2]), 64'd1);
    tick();
    req_valid[2] = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_output("abort_ready", 64'(req_ready[2]), 64'd0);
    check_output("abort_valid", 64'(resp_valid[2]), 64'd0);
    check_output("abort_inst", 64'(resp_inst[2]), 64'd0);
    check_output("abort_ren", 64'(mem_ren[2]), 64'd0);
    check_output("abort_idle_ready", 64'(req_ready[0]), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #2;
    check_output("abort_release_ready", 64'(req_ready[2]), 64'd1);
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      #2;
      check_output("no_stale_resp", 64'(resp_valid[2]), 64'd0);
    end
    resp_ready = 1'b0;
    apply_stimulus(2, 4, 64'h8000_000C, 1'b0, 32'h1000_0001, 0, 1'b0);

    $display("[TB] 16-fetch stream, LATENCY=3, resp_ready held high");
    start_cyc = cyc;
    for (int k = 0; k < 16; k++) begin
      pc = 64'h8000_0000 + 64'(k * 4);
      apply_stimulus(1, 3, pc, 1'b0, model_inst(pc), 0, 1'b1);
    end
    check_output("stream_cycles", 64'(cyc - start_cyc), 64'd64);
    resp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
